// File: rtl/mem_bus_arbiter.sv
// ---------------------------------------------------------------------------
// mem_bus_arbiter
//
// Two-master, single-slave memory bus arbiter. The CPU (m0) and the
// peripheral/display master (m1) share one memory port. When both request at
// once, ownership alternates between them. The winning request is latched, so
// the other master may change its own inputs while it waits without affecting
// the transaction in flight. A slave that never acknowledges is abandoned
// after TIMEOUT cycles in WAIT, and the master gets an error completion.
//
// Parameters
//   TIMEOUT    cycles spent in WAIT before the transaction is aborted (1..15)
//
// Ports
//   clk        clock, rising edge
//   reset      asynchronous, active-high reset
//   m0_*       CPU master: req/we/addr/wdata in, rdata/ready out
//   m1_*       peripheral master: same meaning as m0_*
//   mem_*      slave side: en/we/addr/wdata out, rdata/ack in
//   grant      one-hot current owner ({m1, m0}), cleared when idle
//   busy       a transaction is in progress
//   err        timeout flag, qualified by the owner's ready pulse
//
// All outputs are driven directly by registers.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | no owner; arbitrate between pending requests
// ST_ISSUE | mem_en pulse with the latched request on the slave port
// ST_WAIT  | waiting for mem_ack; timeout counter running
// ST_RESP  | owner's ready pulse with its rdata and err valid
// ---------------------------------------------------------------------------
module mem_bus_arbiter #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic [31:0] m0_rdata,
    output logic        m0_ready,

    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic [31:0] m1_rdata,
    output logic        m1_ready,

    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,

    output logic [1:0]  grant,
    output logic        busy,
    output logic        err
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP
    } state_t;

    // The counter value seen on the last permitted WAIT cycle. The counter is
    // zero on the first WAIT cycle, so WAIT lasts exactly TIMEOUT cycles.
    localparam logic [3:0] TO_LAST = 4'(TIMEOUT - 1);

    state_t      r_state;
    state_t      w_state_nxt;

    // 0 = m0 owned the bus last, 1 = m1 owned it last.
    logic        r_last_grant;
    logic        w_last_grant_nxt;
    logic [3:0]  r_cnt;
    logic [3:0]  w_cnt_nxt;

    logic        r_mem_en;
    logic        w_mem_en_nxt;
    logic        r_mem_we;
    logic        w_mem_we_nxt;
    logic [31:0] r_mem_addr;
    logic [31:0] w_mem_addr_nxt;
    logic [31:0] r_mem_wdata;
    logic [31:0] w_mem_wdata_nxt;

    logic [1:0]  r_grant;
    logic [1:0]  w_grant_nxt;
    logic        r_busy;
    logic        w_busy_nxt;
    logic        r_err;
    logic        w_err_nxt;

    logic        r_m0_ready;
    logic        w_m0_ready_nxt;
    logic        r_m1_ready;
    logic        w_m1_ready_nxt;
    logic [31:0] r_m0_rdata;
    logic [31:0] w_m0_rdata_nxt;
    logic [31:0] r_m1_rdata;
    logic [31:0] w_m1_rdata_nxt;

    logic        w_pick_m1;
    logic        w_done;
    logic        w_timeout;
    logic [31:0] w_resp_data;

    // m1 wins when it is the only requester, or on a tie when m0 owned the
    // bus last.
    assign w_pick_m1 = m1_req & (~m0_req | ~r_last_grant);

    // mem_ack only matters while in WAIT; it takes priority over a timeout
    // falling on the same cycle.
    assign w_done      = (r_state == ST_WAIT) & mem_ack;
    assign w_timeout   = (r_state == ST_WAIT) & ~mem_ack & (r_cnt == TO_LAST);
    assign w_resp_data = mem_ack ? mem_rdata : 32'h0000_0000;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_last_grant_nxt = r_last_grant;
        w_cnt_nxt        = r_cnt;
        w_mem_en_nxt     = 1'b0;
        w_mem_we_nxt     = r_mem_we;
        w_mem_addr_nxt   = r_mem_addr;
        w_mem_wdata_nxt  = r_mem_wdata;
        w_grant_nxt      = r_grant;
        w_busy_nxt       = r_busy;
        w_err_nxt        = 1'b0;
        w_m0_ready_nxt   = 1'b0;
        w_m1_ready_nxt   = 1'b0;
        w_m0_rdata_nxt   = r_m0_rdata;
        w_m1_rdata_nxt   = r_m1_rdata;

        case (r_state)
            ST_IDLE: begin
                w_grant_nxt = 2'b00;
                w_busy_nxt  = 1'b0;
                if (m0_req | m1_req) begin
                    w_state_nxt      = ST_ISSUE;
                    w_last_grant_nxt = w_pick_m1;
                    w_cnt_nxt        = 4'd0;
                    w_mem_en_nxt     = 1'b1;
                    w_busy_nxt       = 1'b1;
                    if (w_pick_m1) begin
                        w_grant_nxt     = 2'b10;
                        w_mem_we_nxt    = m1_we;
                        w_mem_addr_nxt  = m1_addr;
                        w_mem_wdata_nxt = m1_wdata;
                    end else begin
                        w_grant_nxt     = 2'b01;
                        w_mem_we_nxt    = m0_we;
                        w_mem_addr_nxt  = m0_addr;
                        w_mem_wdata_nxt = m0_wdata;
                    end
                end
            end

            ST_ISSUE: begin
                w_state_nxt = ST_WAIT;
            end

            ST_WAIT: begin
                if (w_done || w_timeout) begin
                    w_state_nxt = ST_RESP;
                    w_err_nxt   = w_timeout;
                    // Only the owner's data register and ready pulse move;
                    // the other master keeps its last result.
                    if (r_grant[1]) begin
                        w_m1_ready_nxt = 1'b1;
                        w_m1_rdata_nxt = w_resp_data;
                    end else begin
                        w_m0_ready_nxt = 1'b1;
                        w_m0_rdata_nxt = w_resp_data;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 4'd1;
                end
            end

            ST_RESP: begin
                w_state_nxt = ST_IDLE;
                w_grant_nxt = 2'b00;
                w_busy_nxt  = 1'b0;
            end

            default: begin
                w_state_nxt = ST_IDLE;
                w_grant_nxt = 2'b00;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_last_grant <= 1'b1;
            r_cnt        <= 4'd0;
            r_mem_en     <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= 32'h0000_0000;
            r_mem_wdata  <= 32'h0000_0000;
            r_grant      <= 2'b00;
            r_busy       <= 1'b0;
            r_err        <= 1'b0;
            r_m0_ready   <= 1'b0;
            r_m1_ready   <= 1'b0;
            r_m0_rdata   <= 32'h0000_0000;
            r_m1_rdata   <= 32'h0000_0000;
        end else begin
            r_last_grant <= w_last_grant_nxt;
            r_cnt        <= w_cnt_nxt;
            r_mem_en     <= w_mem_en_nxt;
            r_mem_we     <= w_mem_we_nxt;
            r_mem_addr   <= w_mem_addr_nxt;
            r_mem_wdata  <= w_mem_wdata_nxt;
            r_grant      <= w_grant_nxt;
            r_busy       <= w_busy_nxt;
            r_err        <= w_err_nxt;
            r_m0_ready   <= w_m0_ready_nxt;
            r_m1_ready   <= w_m1_ready_nxt;
            r_m0_rdata   <= w_m0_rdata_nxt;
            r_m1_rdata   <= w_m1_rdata_nxt;
        end
    end

    assign mem_en    = r_mem_en;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign grant     = r_grant;
    assign busy      = r_busy;
    assign err       = r_err;
    assign m0_ready  = r_m0_ready;
    assign m1_ready  = r_m1_ready;
    assign m0_rdata  = r_m0_rdata;
    assign m1_rdata  = r_m1_rdata;

endmodule
